// File: rtl/irq_pkg.sv
// Shared constants for the interrupt pulse generator: register map and line mode encoding.
package irq_pkg;

  // Register select values on cfg_addr
  localparam logic [1:0] IRQ_ENABLE  = 2'd0;
  localparam logic [1:0] IRQ_MODE    = 2'd1;
  localparam logic [1:0] IRQ_RELOAD  = 2'd2;
  localparam logic [1:0] IRQ_PENDING = 2'd3;

  // Must match the width of the control register file's interrupt input
  parameter int unsigned NUM_LINES_DEFAULT = 16;

  typedef enum logic {
    MODE_LEVEL = 1'b0,
    MODE_EDGE  = 1'b1
  } irq_mode_e;

endpackage

// File: rtl/irq_sync_edge.sv
// One request line: 2-flop synchronizer, delayed copy, and rising-edge detect.
module irq_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,   // raw asynchronous request
  input  logic resync_i,  // mode change this cycle: do not report it as an edge
  output logic level_o,   // synchronized level (s2)
  output logic rise_o     // s2 & ~s2_d
);

  logic s1_d, s1_q;
  logic s2_d, s2_q;
  logic s2_dly_d, s2_dly_q;

  // Synchronizer chain advances every cycle, independent of clk_en
  always_comb begin
    s1_d     = async_i;
    s2_d     = s1_q;
    s2_dly_d = s2_q;
  end

  // Synchronizer and delay flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s2_dly_q <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s2_dly_q <= s2_dly_d;
    end
  end

  // Edge output; a mode write treats s2_d as equal to s2 for this cycle
  always_comb begin
    level_o = s2_q;
    rise_o  = s2_q & ~s2_dly_q & ~resync_i;
  end

endmodule

// File: rtl/irq_pulse_gen.sv
// Converts device request lines and an interval timer into one-cycle interrupt pulses.
module irq_pulse_gen
  import irq_pkg::*;
#(
  parameter int unsigned NUM_LINES     = NUM_LINES_DEFAULT,
  parameter int unsigned TIMER_LINE    = 0,
  parameter int unsigned LEVEL_HOLDOFF = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_en,
  input  logic [NUM_LINES-1:0] irq_req,
  input  logic                 cfg_wen,
  input  logic [1:0]           cfg_addr,
  input  logic [31:0]          cfg_wdata,
  output logic [31:0]          cfg_rdata,
  output logic [NUM_LINES-1:0] interrupts
);

  localparam int unsigned HoldW = $clog2(LEVEL_HOLDOFF);
  typedef logic [NUM_LINES-1:0] vec_t;
  localparam vec_t TimerMask = vec_t'(1) << TIMER_LINE;
  localparam logic [HoldW-1:0] HoldMax = '1;

  vec_t enable_d, enable_q;
  vec_t mode_d, mode_q;
  vec_t pending_d, pending_q;
  vec_t irq_d, irq_q;
  logic [31:0] reload_d, reload_q;
  logic [31:0] count_d, count_q;
  logic [31:0] rdata_d, rdata_q;
  logic [HoldW-1:0] holdoff_d, holdoff_q;

  vec_t s2, rise, mode_resync, line_evt, evt, pend_eff, wdata_vec;
  logic wr_enable, wr_mode, wr_reload, wr_pending;
  logic wrap, timer_evt;

  assign wdata_vec  = cfg_wdata[NUM_LINES-1:0];
  assign wr_enable  = clk_en & cfg_wen & (cfg_addr == IRQ_ENABLE);
  assign wr_mode    = clk_en & cfg_wen & (cfg_addr == IRQ_MODE);
  assign wr_reload  = clk_en & cfg_wen & (cfg_addr == IRQ_RELOAD);
  assign wr_pending = clk_en & cfg_wen & (cfg_addr == IRQ_PENDING);
  // Only lines whose mode actually changes are resynchronized
  assign mode_resync = wr_mode ? (wdata_vec ^ mode_q) : '0;
  assign wrap        = clk_en & (holdoff_q == HoldMax);

  for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
    irq_sync_edge u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_i  (irq_req[g]),
      .resync_i (mode_resync[g]),
      .level_o  (s2[g]),
      .rise_o   (rise[g])
    );
  end

  // Timer countdown and level-mode holdoff counter, both clocked by clk_en
  always_comb begin
    reload_d  = reload_q;
    count_d   = count_q;
    holdoff_d = holdoff_q;
    timer_evt = 1'b0;
    if (clk_en) begin
      holdoff_d = holdoff_q + HoldW'(1);
      if (wr_reload) begin
        reload_d = cfg_wdata;
        count_d  = cfg_wdata;
      end else if (reload_q != '0) begin
        if (count_q == 32'd1) begin
          timer_evt = 1'b1;
          count_d   = reload_q;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
    end
  end

  // Per-line events: edge on rise, level on rise or holdoff wrap while high
  always_comb begin
    line_evt = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      unique case (irq_mode_e'(mode_q[i]))
        MODE_EDGE:  line_evt[i] = rise[i];
        MODE_LEVEL: line_evt[i] = rise[i] | (s2[i] & wrap);
      endcase
    end
    if (timer_evt) line_evt = line_evt | TimerMask;
    evt = line_evt & enable_q;
  end

  // Pending collection, pulse emission, register writes and read mux
  always_comb begin
    enable_d  = enable_q;
    mode_d    = mode_q;
    pending_d = pending_q;
    rdata_d   = rdata_q;
    irq_d     = '0;
    pend_eff  = pending_q;
    if (clk_en) begin
      if (wr_pending) pend_eff = pend_eff & ~wdata_vec;
      // Lines being disabled lose what they had pending
      if (wr_enable)  pend_eff = pend_eff & ~(enable_q & ~wdata_vec);
      irq_d     = (pend_eff | evt) & enable_q;
      pending_d = '0;
      unique case (cfg_addr)
        IRQ_ENABLE:  rdata_d = 32'(enable_q);
        IRQ_MODE:    rdata_d = 32'(mode_q);
        IRQ_RELOAD:  rdata_d = count_q;
        IRQ_PENDING: rdata_d = 32'(pending_q);
      endcase
      if (wr_enable) enable_d = wdata_vec;
      if (wr_mode)   mode_d   = wdata_vec;
    end else begin
      pending_d = pending_q | evt;
    end
  end

  // Architectural state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q  <= '0;
      mode_q    <= '0;
      pending_q <= '0;
      irq_q     <= '0;
      reload_q  <= '0;
      count_q   <= '0;
      rdata_q   <= '0;
      holdoff_q <= '0;
    end else begin
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
      reload_q  <= reload_d;
      count_q   <= count_d;
      rdata_q   <= rdata_d;
      holdoff_q <= holdoff_d;
    end
  end

  assign interrupts = irq_q;
  assign cfg_rdata  = rdata_q;

endmodule
